// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the multicycle RISC-V control path: FSM state
// encodings, major opcode constants, datapath select encodings and the
// control-word struct. Imported by the control FSM, the ALU decoder and the
// datapath so that every block agrees on the same encodings.
// -----------------------------------------------------------------------------
package riscv_pkg;

  // ---------------------------------------------------------------------------
  // FSM state encodings. Kept as plain 4-bit constants so that legacy
  // netlists and waveform viewers see the same numeric values. Encoding 15
  // is unused and is treated as an illegal state.
  // ---------------------------------------------------------------------------
  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADR   = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_EXEC_I    = 4'd7;
  localparam logic [3:0] S_ALU_WB    = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_JAL       = 4'd10;
  localparam logic [3:0] S_JALR      = 4'd11;
  localparam logic [3:0] S_JALR_WB   = 4'd12;
  localparam logic [3:0] S_LUI       = 4'd13;
  localparam logic [3:0] S_AUIPC     = 4'd14;

  // ---------------------------------------------------------------------------
  // Major opcodes (instruction bits [6:0]).
  // ---------------------------------------------------------------------------
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Bit of the opcode that separates stores (1) from loads (0).
  localparam int unsigned OP_STORE_BIT = 5;

  // ---------------------------------------------------------------------------
  // Datapath select encodings.
  // ---------------------------------------------------------------------------
  localparam logic       ADR_PC         = 1'b0;
  localparam logic       ADR_RESULT     = 1'b1;

  localparam logic [1:0] SRC_A_PC       = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC   = 2'b01;
  localparam logic [1:0] SRC_A_RS1      = 2'b10;

  localparam logic [1:0] SRC_B_RS2      = 2'b00;
  localparam logic [1:0] SRC_B_IMM      = 2'b01;
  localparam logic [1:0] SRC_B_FOUR     = 2'b10;

  localparam logic [1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [1:0] RES_READ_DATA  = 2'b01;
  localparam logic [1:0] RES_ALU_RESULT = 2'b10;

  localparam logic [1:0] ALU_OP_ADD     = 2'b00;
  localparam logic [1:0] ALU_OP_SUB     = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT   = 2'b10;
  localparam logic [1:0] ALU_OP_LUI     = 2'b11;

  // ---------------------------------------------------------------------------
  // Complete control word produced by the FSM in one cycle.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       mem_req;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  // All strobes low, all selects at encoding 0.
  localparam ctrl_t CTRL_IDLE = '0;

  // ---------------------------------------------------------------------------
  // State entered after DECODE for a given opcode. Unsupported opcodes map
  // back to FETCH; callers use that to flag the instruction as illegal.
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] decode_target(input logic [6:0] opcode);
    logic [3:0] target;
    case (opcode)
      OP_LOAD,
      OP_STORE:  target = S_MEM_ADR;
      OP_R:      target = S_EXEC_R;
      OP_I:      target = S_EXEC_I;
      OP_BRANCH: target = S_BRANCH;
      OP_JAL:    target = S_JAL;
      OP_JALR:   target = S_JALR;
      OP_LUI:    target = S_LUI;
      OP_AUIPC:  target = S_AUIPC;
      default:   target = S_FETCH;
    endcase
    return target;
  endfunction

endpackage

// File: rtl/control_fsm_if.sv
// -----------------------------------------------------------------------------
// control_fsm_if
// Connection between the multicycle control FSM and the datapath/memory.
//   opcode_i     [6:0] opcode field of the instruction register
//   mem_ready_i        memory handshake, access completes in the cycle it is 1
//   pc_update_o        unconditional PC write
//   branch_o           conditional PC write (qualified by zero flag in datapath)
//   ir_write_o         instruction register and old-PC capture
//   reg_write_o        register file write
//   mem_write_o        data memory write
//   mem_req_o          memory access request
//   adr_src_o          memory address select
//   alu_src_a_o  [1:0] ALU operand A select
//   alu_src_b_o  [1:0] ALU operand B select
//   result_src_o [1:0] result bus select
//   alu_op_o     [1:0] ALU decoder operation class
//   illegal_o          one-cycle pulse for an unsupported opcode
// Signal suffixes are from the controller's point of view.
// Modports: master = controller, slave = datapath/memory side.
// -----------------------------------------------------------------------------
interface control_fsm_if;

  logic [6:0] opcode_i;
  logic       mem_ready_i;

  logic       pc_update_o;
  logic       branch_o;
  logic       ir_write_o;
  logic       reg_write_o;
  logic       mem_write_o;
  logic       mem_req_o;
  logic       adr_src_o;
  logic [1:0] alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [1:0] result_src_o;
  logic [1:0] alu_op_o;
  logic       illegal_o;

  modport master (
    input  opcode_i,
    input  mem_ready_i,
    output pc_update_o,
    output branch_o,
    output ir_write_o,
    output reg_write_o,
    output mem_write_o,
    output mem_req_o,
    output adr_src_o,
    output alu_src_a_o,
    output alu_src_b_o,
    output result_src_o,
    output alu_op_o,
    output illegal_o
  );

  modport slave (
    output opcode_i,
    output mem_ready_i,
    input  pc_update_o,
    input  branch_o,
    input  ir_write_o,
    input  reg_write_o,
    input  mem_write_o,
    input  mem_req_o,
    input  adr_src_o,
    input  alu_src_a_o,
    input  alu_src_b_o,
    input  result_src_o,
    input  alu_op_o,
    input  illegal_o
  );

endinterface

// File: rtl/control_fsm.sv
// -----------------------------------------------------------------------------
// control_fsm
// Main controller of a multicycle RV32I core. One state register, a
// combinational next-state block and a combinational output block.
// Outputs follow the current state; the only input-dependent outputs are
// the FETCH write strobes (qualified by mem_ready_i) and the DECODE
// illegal-opcode pulse.
//
// Ports:
//   clk_i   clock, all state updates on the rising edge
//   rst_ni  asynchronous active-low reset; forces FETCH and silences all
//           strobes and the memory request while asserted
//   bus     control_fsm_if.master, opcode/handshake in, control word out
//
// Instruction flows (cycles with mem_ready_i tied high):
//   load   FETCH DECODE MEM_ADR MEM_READ MEM_WB          (5)
//   store  FETCH DECODE MEM_ADR MEM_WRITE                (4)
//   R/I    FETCH DECODE EXEC_R|EXEC_I ALU_WB             (4)
//   LUI    FETCH DECODE LUI ALU_WB                       (4)
//   AUIPC  FETCH DECODE AUIPC ALU_WB                     (4)
//   JAL    FETCH DECODE JAL ALU_WB                       (4)
//   JALR   FETCH DECODE JALR JALR_WB                     (4)
//   branch FETCH DECODE BRANCH                           (3)
// Each cycle mem_ready_i is low in FETCH/MEM_READ/MEM_WRITE adds one cycle.
// -----------------------------------------------------------------------------
module control_fsm
  import riscv_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  control_fsm_if.master bus
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  ctrl_t      ctrl;

  // ---------------------------------------------------------------------------
  // State register.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge values; blocking here would create simulation order races.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. The opcode is only looked at in DECODE and MEM_ADR, so
  // the instruction register may change freely in every other state.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = bus.mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE:    state_d = decode_target(bus.opcode_i);
      S_MEM_ADR:   state_d = bus.opcode_i[OP_STORE_BIT] ? S_MEM_WRITE
                                                        : S_MEM_READ;
      S_MEM_READ:  state_d = bus.mem_ready_i ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = bus.mem_ready_i ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R:    state_d = S_ALU_WB;
      S_EXEC_I:    state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JAL:       state_d = S_ALU_WB;
      S_JALR:      state_d = S_JALR_WB;
      S_JALR_WB:   state_d = S_FETCH;
      S_LUI:       state_d = S_ALU_WB;
      S_AUIPC:     state_d = S_ALU_WB;
      // Unused encodings recover to FETCH on the next edge.
      default:     state_d = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode. Anything not set in a state stays at CTRL_IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl = CTRL_IDLE;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.adr_src    = ADR_PC;
        ctrl.alu_src_a  = SRC_A_PC;
        ctrl.alu_src_b  = SRC_B_FOUR;
        ctrl.alu_op     = ALU_OP_ADD;
        ctrl.result_src = RES_ALU_RESULT;
        // IR capture and PC+4 only in the cycle the fetch completes.
        ctrl.ir_write   = bus.mem_ready_i;
        ctrl.pc_update  = bus.mem_ready_i;
      end
      S_DECODE: begin
        // Precompute old_pc + imm as the branch/JAL target.
        ctrl.alu_src_a  = SRC_A_OLD_PC;
        ctrl.alu_src_b  = SRC_B_IMM;
        ctrl.alu_op     = ALU_OP_ADD;
        ctrl.illegal    = (decode_target(bus.opcode_i) == S_FETCH);
      end
      S_MEM_ADR: begin
        ctrl.alu_src_a  = SRC_A_RS1;
        ctrl.alu_src_b  = SRC_B_IMM;
        ctrl.alu_op     = ALU_OP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_req    = 1'b1;
        ctrl.adr_src    = ADR_RESULT;
        ctrl.result_src = RES_ALU_OUT;
      end
      S_MEM_WB: begin
        ctrl.result_src = RES_READ_DATA;
        ctrl.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        // Write strobe is held for the whole wait; memory commits on ready.
        ctrl.mem_req    = 1'b1;
        ctrl.adr_src    = ADR_RESULT;
        ctrl.result_src = RES_ALU_OUT;
        ctrl.mem_write  = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a  = SRC_A_RS1;
        ctrl.alu_src_b  = SRC_B_RS2;
        ctrl.alu_op     = ALU_OP_FUNCT;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a  = SRC_A_RS1;
        ctrl.alu_src_b  = SRC_B_IMM;
        ctrl.alu_op     = ALU_OP_FUNCT;
      end
      S_ALU_WB: begin
        ctrl.result_src = RES_ALU_OUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        // ALU compares rs1-rs2 while the target computed in DECODE sits in
        // the ALU-out register; the datapath gates branch with zero.
        ctrl.alu_src_a  = SRC_A_RS1;
        ctrl.alu_src_b  = SRC_B_RS2;
        ctrl.alu_op     = ALU_OP_SUB;
        ctrl.result_src = RES_ALU_OUT;
        ctrl.branch     = 1'b1;
      end
      S_JAL: begin
        // PC <- target from DECODE while the ALU forms old_pc + 4 for the
        // link value, written back in ALU_WB.
        ctrl.alu_src_a  = SRC_A_OLD_PC;
        ctrl.alu_src_b  = SRC_B_FOUR;
        ctrl.alu_op     = ALU_OP_ADD;
        ctrl.result_src = RES_ALU_OUT;
        ctrl.pc_update  = 1'b1;
      end
      S_JALR: begin
        // PC <- rs1 + imm straight from the ALU result.
        ctrl.alu_src_a  = SRC_A_RS1;
        ctrl.alu_src_b  = SRC_B_IMM;
        ctrl.alu_op     = ALU_OP_ADD;
        ctrl.result_src = RES_ALU_RESULT;
        ctrl.pc_update  = 1'b1;
      end
      S_JALR_WB: begin
        // Link value old_pc + 4 written directly from the ALU result.
        ctrl.alu_src_a  = SRC_A_OLD_PC;
        ctrl.alu_src_b  = SRC_B_FOUR;
        ctrl.alu_op     = ALU_OP_ADD;
        ctrl.result_src = RES_ALU_RESULT;
        ctrl.reg_write  = 1'b1;
      end
      S_LUI: begin
        ctrl.alu_src_b  = SRC_B_IMM;
        ctrl.alu_op     = ALU_OP_LUI;
      end
      S_AUIPC: begin
        ctrl.alu_src_a  = SRC_A_OLD_PC;
        ctrl.alu_src_b  = SRC_B_IMM;
        ctrl.alu_op     = ALU_OP_ADD;
      end
      default: ctrl = CTRL_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output drive. Strobes and the memory request are qualified with rst_ni so
  // they drop the instant reset is asserted, even mid-cycle, without waiting
  // for the state register; selects simply show the FETCH values.
  // ---------------------------------------------------------------------------
  assign bus.pc_update_o  = ctrl.pc_update & rst_ni;
  assign bus.branch_o     = ctrl.branch    & rst_ni;
  assign bus.ir_write_o   = ctrl.ir_write  & rst_ni;
  assign bus.reg_write_o  = ctrl.reg_write & rst_ni;
  assign bus.mem_write_o  = ctrl.mem_write & rst_ni;
  assign bus.mem_req_o    = ctrl.mem_req   & rst_ni;
  assign bus.illegal_o    = ctrl.illegal   & rst_ni;

  assign bus.adr_src_o    = ctrl.adr_src;
  assign bus.alu_src_a_o  = ctrl.alu_src_a;
  assign bus.alu_src_b_o  = ctrl.alu_src_b;
  assign bus.result_src_o = ctrl.result_src;
  assign bus.alu_op_o     = ctrl.alu_op;

endmodule

// File: tb/tb_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_control_fsm
// Directed, table-driven bench for control_fsm. Each table row is one clock
// cycle: the inputs applied in that cycle and the full control word expected
// from the current state. Multi-cycle reset corner cases are hand-written.
// -----------------------------------------------------------------------------
module tb_control_fsm;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       mem_req;
    logic       adr_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       illegal;
  } out_t;

  typedef struct {
    logic [6:0] opcode;
    logic       ready;
    out_t       exp;
  } vec_t;

  localparam logic [6:0] LW    = 7'b0000011;
  localparam logic [6:0] SW    = 7'b0100011;
  localparam logic [6:0] ADD   = 7'b0110011;
  localparam logic [6:0] ADDI  = 7'b0010011;
  localparam logic [6:0] BEQ   = 7'b1100011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] NOP0  = 7'b0000000;
  localparam logic [6:0] ONES  = 7'b1111111;

  logic clk;
  logic rst_n;

  control_fsm_if bus ();

  control_fsm dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int wb_count = 0;

  out_t e_fw, e_fg, e_dec, e_dec_ill, e_madr, e_mrd, e_mwb, e_mwr;
  out_t e_exr, e_exi, e_awb, e_br, e_jal, e_jalr, e_jwb, e_lui, e_aui, e_rst;

  vec_t vecs[$];

  function automatic out_t mk(bit pc, bit br, bit ir, bit rw, bit mw, bit mr,
                              bit as, bit [1:0] a, bit [1:0] b, bit [1:0] rs,
                              bit [1:0] op, bit ill);
    out_t o;
    o.pc_update = pc;  o.branch = br;     o.ir_write = ir;
    o.reg_write = rw;  o.mem_write = mw;  o.mem_req = mr;
    o.adr_src = as;    o.src_a = a;       o.src_b = b;
    o.result_src = rs; o.alu_op = op;     o.illegal = ill;
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.pc_update  = bus.pc_update_o;
    o.branch     = bus.branch_o;
    o.ir_write   = bus.ir_write_o;
    o.reg_write  = bus.reg_write_o;
    o.mem_write  = bus.mem_write_o;
    o.mem_req    = bus.mem_req_o;
    o.adr_src    = bus.adr_src_o;
    o.src_a      = bus.alu_src_a_o;
    o.src_b      = bus.alu_src_b_o;
    o.result_src = bus.result_src_o;
    o.alu_op     = bus.alu_op_o;
    o.illegal    = bus.illegal_o;
    return o;
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (pc,br,ir,rw,mw,mr,as,a,b,rs,op,ill)",
               name, act, exp);
    end
  endtask

  task automatic add(input logic [6:0] op, input logic rdy, input out_t exp);
    vec_t v;
    v.opcode = op;
    v.ready  = rdy;
    v.exp    = exp;
    vecs.push_back(v);
  endtask

  // One cycle: inputs driven after the falling edge, outputs checked 1 ns later.
  task automatic run_row(input logic [6:0] op, input logic rdy, input out_t exp,
                         input string name);
    out_t act;
    @(negedge clk);
    bus.opcode_i    = op;
    bus.mem_ready_i = rdy;
    #1;
    act = sample();
    if (act.reg_write === 1'b1 && act.result_src === 2'b01) wb_count++;
    check(name, act, exp);
  endtask

  // Assert reset between edges and check the strobes drop at once.
  task automatic async_reset(input string name);
    #2;
    rst_n           = 1'b0;
    bus.mem_ready_i = 1'b1;
    #1;
    check({name, "_now"}, sample(), e_rst);
    @(posedge clk);
    #1;
    check({name, "_held"}, sample(), e_rst);
  endtask

  task automatic release_rst(input string name);
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    rst_n           = 1'b1;
    #1;
    check(name, sample(), e_fw);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            pc br ir rw mw mr as a      b      rs     op     ill
    e_fw      = mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0);
    e_fg      = mk(1, 0, 1, 0, 0, 1, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0);
    e_dec     = mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0);
    e_dec_ill = mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 1);
    e_madr    = mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0);
    e_mrd     = mk(0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    e_mwb     = mk(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 0);
    e_mwr     = mk(0, 0, 0, 0, 1, 1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    e_exr     = mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b10, 0);
    e_exi     = mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b10, 0);
    e_awb     = mk(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    e_br      = mk(0, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b01, 0);
    e_jal     = mk(1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0);
    e_jalr    = mk(1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, 0);
    e_jwb     = mk(0, 0, 0, 1, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00, 0);
    e_lui     = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b11, 0);
    e_aui     = mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0);
    e_rst     = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0);

    // addi: opcode junk after DECODE must be ignored
    add(ADDI, 1, e_fg); add(ADDI, 0, e_dec); add(NOP0, 0, e_exi); add(BEQ, 1, e_awb);
    // add with two fetch wait cycles
    add(NOP0, 0, e_fw); add(NOP0, 0, e_fw); add(ADD, 1, e_fg); add(ADD, 1, e_dec);
    add(LW, 1, e_exr);  add(NOP0, 1, e_awb);
    // sw, ready high: 4 cycles, one mem_write cycle
    add(NOP0, 1, e_fg); add(SW, 1, e_dec); add(SW, 1, e_madr); add(ADD, 1, e_mwr);
    // beq: 3 cycles
    add(NOP0, 1, e_fg); add(BEQ, 1, e_dec); add(ADD, 1, e_br);
    // jal, jalr, lui, auipc
    add(NOP0, 1, e_fg); add(JAL, 1, e_dec);   add(NOP0, 1, e_jal);  add(NOP0, 1, e_awb);
    add(NOP0, 1, e_fg); add(JALR, 1, e_dec);  add(NOP0, 1, e_jalr); add(NOP0, 1, e_jwb);
    add(NOP0, 1, e_fg); add(LUI, 1, e_dec);   add(NOP0, 1, e_lui);  add(NOP0, 1, e_awb);
    add(NOP0, 1, e_fg); add(AUIPC, 1, e_dec); add(NOP0, 1, e_aui);  add(NOP0, 1, e_awb);
    // illegal opcodes: pulse in DECODE, straight back to FETCH
    add(NOP0, 1, e_fg); add(NOP0, 1, e_dec_ill); add(NOP0, 0, e_fw);
    add(NOP0, 1, e_fg); add(ONES, 1, e_dec_ill); add(NOP0, 0, e_fw);
    // store with two memory wait cycles
    add(NOP0, 1, e_fg); add(SW, 0, e_dec); add(SW, 0, e_madr);
    add(NOP0, 0, e_mwr); add(NOP0, 0, e_mwr); add(NOP0, 1, e_mwr);
    // load/store choice taken from the opcode seen in MEM_ADR
    add(NOP0, 1, e_fg); add(SW, 1, e_dec); add(LW, 1, e_madr);
    add(NOP0, 1, e_mrd); add(NOP0, 1, e_mwb); add(NOP0, 0, e_fw);

    // Reset state, checked before any clock edge and across edges
    rst_n           = 1'b0;
    bus.opcode_i    = NOP0;
    bus.mem_ready_i = 1'b1;
    #3;
    check("reset_initial", sample(), e_rst);
    repeat (2) @(posedge clk);
    #1;
    check("reset_clocked", sample(), e_rst);
    release_rst("reset_release");

    for (int i = 0; i < vecs.size(); i++) begin
      run_row(vecs[i].opcode, vecs[i].ready, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // lw with MEM_READ wait of two cycles; exactly one read-data writeback
    wb_count = 0;
    run_row(NOP0, 1, e_fg,  "lw_fetch");
    run_row(LW,   0, e_dec, "lw_decode");
    run_row(LW,   0, e_madr, "lw_memadr");
    run_row(NOP0, 0, e_mrd, "lw_read_wait1");
    run_row(NOP0, 0, e_mrd, "lw_read_wait2");
    run_row(NOP0, 1, e_mrd, "lw_read_done");
    run_row(NOP0, 0, e_mwb, "lw_writeback");
    run_row(NOP0, 0, e_fw,  "lw_back_to_fetch");
    n_checks++;
    if (wb_count != 1) begin
      n_fail++;
      $display("FAIL lw_wb_count: got %0d required 1", wb_count);
    end

    // Reset mid-EXEC_R, then a clean instruction afterwards
    run_row(NOP0, 1, e_fg,  "rx_fetch");
    run_row(ADD,  1, e_dec, "rx_decode");
    run_row(NOP0, 1, e_exr, "rx_exec_r");
    async_reset("rst_exec_r");
    release_rst("rst_exec_r_release");
    run_row(ADDI, 1, e_fg,  "rx2_fetch");
    run_row(ADDI, 1, e_dec, "rx2_decode");
    run_row(NOP0, 1, e_exi, "rx2_exec_i");
    run_row(NOP0, 1, e_awb, "rx2_alu_wb");

    // Reset during a store's memory wait: the write is abandoned
    run_row(NOP0, 1, e_fg,   "rw_fetch");
    run_row(SW,   1, e_dec,  "rw_decode");
    run_row(SW,   1, e_madr, "rw_memadr");
    run_row(NOP0, 0, e_mwr,  "rw_write_wait");
    async_reset("rst_mem_wait");
    release_rst("rst_mem_wait_release");
    run_row(NOP0, 1, e_fg,   "rw2_fetch");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
